// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encodings and frame constants for the boot loader
package prog_loader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LEN_LO = ST_LEN_LO,
        S_LEN_HI = ST_LEN_HI,
        S_DATA   = ST_DATA,
        S_CSUM   = ST_CSUM,
        S_DONE   = ST_DONE,
        S_ERROR  = ST_ERROR
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in, instruction memory write bus out
interface prog_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/prog_loader_word_asm.sv
// rtl/prog_loader_word_asm.sv - little-endian word assembly and memory write strobe
module prog_loader_word_asm
    import prog_loader_pkg::*;
#(
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             byte_en,
    input  logic [7:0]       byte_in,
    output logic             last_byte,
    output logic [IDX_W-1:0] word_idx,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata
);

    logic [1:0]  byte_cnt;
    logic [23:0] shreg;

    assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

    // Shift bytes in from the top so the first byte ends up in [7:0]; the
    // fourth byte completes the word and fires a one-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= '0;
            shreg      <= '0;
            word_idx   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (clr) begin
                byte_cnt <= '0;
                shreg    <= '0;
                word_idx <= '0;
            end else if (byte_en) begin
                shreg    <= {byte_in, shreg[23:8]};
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= {{(30 - IDX_W){1'b0}}, word_idx, 2'b00};
                    imem_wdata <= {byte_in, shreg};
                    word_idx   <= word_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-serial boot loader holding the core in reset until a good load
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         MEM_DEPTH      = 256,
    parameter logic [7:0] MAGIC          = MAGIC_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus,
    output logic         core_rst,
    output logic         load_done,
    output logic         load_error
);

    localparam int IDX_W = $clog2(MEM_DEPTH) + 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES);

    state_t           state, state_next;
    logic [TW-1:0]    tcnt;
    logic [15:0]      len;
    logic [7:0]       xor_acc;
    logic             accept, active, timeout, take;
    logic [15:0]      n_hdr;
    logic             last_byte, last_word;
    logic [IDX_W-1:0] word_idx;

    assign accept    = bus.rx_valid & bus.rx_ready;
    assign active    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CSUM);
    assign timeout   = active && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    // A byte arriving in the cycle the timeout fires is thrown away.
    assign take      = accept && !timeout;
    assign n_hdr     = {bus.rx_data, len[7:0]};
    assign last_word = ({{(16 - IDX_W){1'b0}}, word_idx} == (len - 16'd1));

    prog_loader_word_asm #(.IDX_W(IDX_W)) u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (take && (state == S_LEN_HI)),
        .byte_en    (take && (state == S_DATA)),
        .byte_in    (bus.rx_data),
        .last_byte  (last_byte),
        .word_idx   (word_idx),
        .imem_we    (bus.imem_we),
        .imem_addr  (bus.imem_addr),
        .imem_wdata (bus.imem_wdata)
    );

    // State register, length capture, data checksum and inter-byte timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            tcnt    <= '0;
            len     <= '0;
            xor_acc <= '0;
        end else begin
            state <= state_next;
            tcnt  <= (active && !accept && !timeout) ? tcnt + 1'b1 : '0;
            if (take) begin
                case (state)
                    S_LEN_LO: len[7:0] <= bus.rx_data;
                    S_LEN_HI: begin
                        len[15:8] <= bus.rx_data;
                        xor_acc   <= '0;
                    end
                    S_DATA:   xor_acc <= xor_acc ^ bus.rx_data;
                    default:  ;
                endcase
            end
        end
    end

    // Next state on each accepted byte (or timeout) and state-decoded outputs.
    always_comb begin
        state_next   = state;
        bus.rx_ready = 1'b1;
        core_rst     = (state != S_DONE);
        load_done    = (state == S_DONE);
        load_error   = (state == S_ERROR);
        if (timeout) begin
            state_next = S_ERROR;
        end else if (accept) begin
            case (state)
                S_IDLE, S_DONE, S_ERROR:
                    if (bus.rx_data == MAGIC) state_next = S_LEN_LO;
                S_LEN_LO: state_next = S_LEN_HI;
                S_LEN_HI: begin
                    if (n_hdr == 16'd0)                  state_next = S_CSUM;
                    else if (n_hdr > 16'(MEM_DEPTH))     state_next = S_ERROR;
                    else                                 state_next = S_DATA;
                end
                S_DATA:
                    if (last_byte && last_word) state_next = S_CSUM;
                S_CSUM:
                    state_next = (bus.rx_data == xor_acc) ? S_DONE : S_ERROR;
                default: state_next = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst;
    logic core_rst, load_done, load_error;
    int   checks = 0;
    int   fails  = 0;
    int   base;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always #5 clk = ~clk;

    prog_loader_if bus ();

    prog_loader #(
        .MEM_DEPTH      (256),
        .MAGIC          (8'hA5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame1(input logic [7:0] csum);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(csum);
    endtask

    task automatic test_reset();
        #1;
        checks += 7;
        if (core_rst !== 1'b1) begin fails++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
        if (bus.rx_ready !== 1'b1) begin fails++; $display("FAIL reset_rx_ready: got %b expected 1", bus.rx_ready); end
        if (bus.imem_we !== 1'b0) begin fails++; $display("FAIL reset_imem_we: got %b expected 0", bus.imem_we); end
        if (bus.imem_addr !== 32'h0) begin fails++; $display("FAIL reset_imem_addr: got %h expected 0", bus.imem_addr); end
        if (bus.imem_wdata !== 32'h0) begin fails++; $display("FAIL reset_imem_wdata: got %h expected 0", bus.imem_wdata); end
        if (load_done !== 1'b0) begin fails++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
        if (load_error !== 1'b0) begin fails++; $display("FAIL reset_load_error: got %b expected 0", load_error); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_good_frame();
        base = wr_addr.size();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks += 3;
        if (bus.imem_we !== 1'b1) begin fails++; $display("FAIL good_we_latency: got %b expected 1", bus.imem_we); end
        if (bus.imem_addr !== 32'h0) begin fails++; $display("FAIL good_addr0: got %h expected 00000000", bus.imem_addr); end
        if (bus.imem_wdata !== 32'h00000013) begin fails++; $display("FAIL good_data0: got %h expected 00000013", bus.imem_wdata); end
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        checks += 3;
        if (bus.imem_we !== 1'b1) begin fails++; $display("FAIL good_we1: got %b expected 1", bus.imem_we); end
        if (bus.imem_addr !== 32'h4) begin fails++; $display("FAIL good_addr1: got %h expected 00000004", bus.imem_addr); end
        if (bus.imem_wdata !== 32'h00100093) begin fails++; $display("FAIL good_data1: got %h expected 00100093", bus.imem_wdata); end
        send_byte(8'h90);
        checks += 5;
        if (load_done !== 1'b1) begin fails++; $display("FAIL good_load_done: got %b expected 1", load_done); end
        if (core_rst !== 1'b0) begin fails++; $display("FAIL good_core_rst: got %b expected 0", core_rst); end
        if (load_error !== 1'b0) begin fails++; $display("FAIL good_load_error: got %b expected 0", load_error); end
        if (wr_addr.size() - base !== 2) begin fails++; $display("FAIL good_write_count: got %0d expected 2", wr_addr.size() - base); end
        if (bus.imem_wdata !== 32'h00100093) begin fails++; $display("FAIL good_wdata_hold: got %h expected 00100093", bus.imem_wdata); end
    endtask

    task automatic test_bad_csum();
        base = wr_addr.size();
        send_byte(8'hA5);
        checks += 2;
        if (core_rst !== 1'b1) begin fails++; $display("FAIL restart_core_rst: got %b expected 1", core_rst); end
        if (load_done !== 1'b0) begin fails++; $display("FAIL restart_load_done: got %b expected 0", load_done); end
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h91);
        @(negedge clk);
        checks += 6;
        if (load_error !== 1'b1) begin fails++; $display("FAIL bad_load_error: got %b expected 1", load_error); end
        if (load_done !== 1'b0) begin fails++; $display("FAIL bad_load_done: got %b expected 0", load_done); end
        if (core_rst !== 1'b1) begin fails++; $display("FAIL bad_core_rst: got %b expected 1", core_rst); end
        if (wr_addr.size() - base !== 2) begin fails++; $display("FAIL bad_write_count: got %0d expected 2", wr_addr.size() - base); end
        else begin
            if (wr_data[base] !== 32'h00000013) begin fails++; $display("FAIL bad_data0: got %h expected 00000013", wr_data[base]); end
            if (wr_addr[base+1] !== 32'h4) begin fails++; $display("FAIL bad_addr1: got %h expected 00000004", wr_addr[base+1]); end
        end
    endtask

    task automatic test_junk();
        do_reset();
        base = wr_addr.size();
        send_byte(8'h00); send_byte(8'hFF);
        checks += 1;
        if (core_rst !== 1'b1) begin fails++; $display("FAIL junk_core_rst: got %b expected 1", core_rst); end
        send_frame1(8'h90);
        @(negedge clk);
        checks += 4;
        if (load_done !== 1'b1) begin fails++; $display("FAIL junk_load_done: got %b expected 1", load_done); end
        if (wr_addr.size() - base !== 2) begin fails++; $display("FAIL junk_write_count: got %0d expected 2", wr_addr.size() - base); end
        else begin
            if (wr_addr[base] !== 32'h0) begin fails++; $display("FAIL junk_addr0: got %h expected 00000000", wr_addr[base]); end
            if (wr_data[base+1] !== 32'h00100093) begin fails++; $display("FAIL junk_data1: got %h expected 00100093", wr_data[base+1]); end
        end
    endtask

    task automatic test_too_long();
        base = wr_addr.size();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        checks += 2;
        if (load_error !== 1'b1) begin fails++; $display("FAIL long_load_error: got %b expected 1", load_error); end
        if (core_rst !== 1'b1) begin fails++; $display("FAIL long_core_rst: got %b expected 1", core_rst); end
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        checks += 2;
        if (wr_addr.size() - base !== 0) begin fails++; $display("FAIL long_write_count: got %0d expected 0", wr_addr.size() - base); end
        if (load_error !== 1'b1) begin fails++; $display("FAIL long_error_hold: got %b expected 1", load_error); end
    endtask

    task automatic test_max_len();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        checks += 1;
        if (load_error !== 1'b0) begin fails++; $display("FAIL maxlen_load_error: got %b expected 0", load_error); end
        do_reset();
    endtask

    task automatic test_zero_len();
        base = wr_addr.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        checks += 3;
        if (load_done !== 1'b1) begin fails++; $display("FAIL zero_load_done: got %b expected 1", load_done); end
        if (core_rst !== 1'b0) begin fails++; $display("FAIL zero_core_rst: got %b expected 0", core_rst); end
        if (wr_addr.size() - base !== 0) begin fails++; $display("FAIL zero_write_count: got %0d expected 0", wr_addr.size() - base); end
    endtask

    task automatic test_timeout();
        base = wr_addr.size();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13);
        repeat (15) @(posedge clk);
        #1;
        checks += 1;
        if (load_error !== 1'b0) begin fails++; $display("FAIL timeout_early: got %b expected 0", load_error); end
        @(posedge clk);
        #1;
        checks += 3;
        if (load_error !== 1'b1) begin fails++; $display("FAIL timeout_load_error: got %b expected 1", load_error); end
        if (core_rst !== 1'b1) begin fails++; $display("FAIL timeout_core_rst: got %b expected 1", core_rst); end
        if (wr_addr.size() - base !== 0) begin fails++; $display("FAIL timeout_write_count: got %0d expected 0", wr_addr.size() - base); end
        send_frame1(8'h90);
        checks += 1;
        if (load_done !== 1'b1) begin fails++; $display("FAIL timeout_recover: got %b expected 1", load_done); end
    endtask

    task automatic test_midframe_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93);
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (core_rst !== 1'b1) begin fails++; $display("FAIL midrst_core_rst: got %b expected 1", core_rst); end
        if (bus.imem_addr !== 32'h0) begin fails++; $display("FAIL midrst_imem_addr: got %h expected 0", bus.imem_addr); end
        if (bus.imem_wdata !== 32'h0) begin fails++; $display("FAIL midrst_imem_wdata: got %h expected 0", bus.imem_wdata); end
        if (load_done !== 1'b0) begin fails++; $display("FAIL midrst_load_done: got %b expected 0", load_done); end
        if (load_error !== 1'b0) begin fails++; $display("FAIL midrst_load_error: got %b expected 0", load_error); end
        @(negedge clk);
        rst = 1'b0;
        base = wr_addr.size();
        send_frame1(8'h90);
        @(negedge clk);
        checks += 3;
        if (load_done !== 1'b1) begin fails++; $display("FAIL midrst_reload_done: got %b expected 1", load_done); end
        if (wr_addr.size() - base !== 2) begin fails++; $display("FAIL midrst_write_count: got %0d expected 2", wr_addr.size() - base); end
        else if (wr_data[base] !== 32'h00000013) begin fails++; $display("FAIL midrst_data0: got %h expected 00000013", wr_data[base]); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_junk();
        test_too_long();
        test_max_len();
        test_zero_len();
        test_timeout();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
